card_ctl: RTL



---
 rtl/card_ctl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/card_ctl.sv
// Memory-game controller: fills the card register file from the shuffler,
// then turns player clicks into discover / cover / remove writes.
module card_ctl #(
  parameter int SHOW_CYCLES = 65_000_000,
  parameter int CNT_W       = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        click,
  input  logic [3:0]  click_addr,
  input  logic [11:0] init_color,
  output logic [3:0]  init_addr,
  input  logic [13:0] rf_r_data,
  output logic [3:0]  rf_r_address,
  output logic [1:0]  rf_w_enable,
  output logic [3:0]  rf_w_address,
  output logic [13:0] rf_w_data,
  output logic [2:0]  pairs_found,
  output logic [7:0]  moves,
  output logic        game_done,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, INIT, WAIT1, CHK1, WAIT2, CHK2, SHOW, RES1, RES2, DONE
  } state_t;

  localparam logic [1:0] WR_FULL = 2'b01;
  localparam logic [1:0] WR_BITS = 2'b10;

  state_t           state, nxt;
  logic [4:0]       idx;
  logic [3:0]       a1, a2;
  logic [11:0]      c1, c2;
  logic [CNT_W-1:0] cnt;
  logic             covered;
  logic             matched;
  logic [1:0]       resolve;

  function automatic logic playable(input logic [3:0] a);
    return (a != 4'h0) && (a <= 4'hC);
  endfunction

  assign covered = (rf_r_data[1:0] == 2'b01);
  assign matched = (c1 == c2);
  assign resolve = matched ? 2'b00 : 2'b01;

  // Next-state decode; start wins over everything, including a pending resolve.
  always_comb begin
    nxt = state;
    if (start) begin
      nxt = INIT;
    end else begin
      case (state)
        IDLE:  nxt = IDLE;
        INIT:  if (idx[4]) nxt = WAIT1;
        WAIT1: if (click && playable(click_addr)) nxt = CHK1;
        CHK1:  nxt = covered ? WAIT2 : WAIT1;
        WAIT2: if (click && playable(click_addr)) nxt = CHK2;
        CHK2:  nxt = covered ? SHOW : WAIT2;
        SHOW:  if (cnt == '0) nxt = RES1;
        RES1:  nxt = RES2;
        RES2:  nxt = (matched && pairs_found == 3'd5) ? DONE : WAIT1;
        DONE:  nxt = DONE;
        default: nxt = IDLE;
      endcase
    end
  end

  // Writes are registered one cycle after the decision, so each lands in the
  // cycle the state register already reflects the step it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      a1           <= '0;
      a2           <= '0;
      c1           <= '0;
      c2           <= '0;
      cnt          <= '0;
      init_addr    <= '0;
      rf_r_address <= '0;
      rf_w_enable  <= '0;
      rf_w_address <= '0;
      rf_w_data    <= '0;
      pairs_found  <= '0;
      moves        <= '0;
      game_done    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state       <= nxt;
      busy        <= (nxt == INIT) || (nxt == CHK1) || (nxt == CHK2) ||
                     (nxt == SHOW) || (nxt == RES1) || (nxt == RES2);
      game_done   <= (nxt == DONE);
      rf_w_enable <= 2'b00;
      if (start) begin
        idx         <= '0;
        init_addr   <= '0;
        pairs_found <= '0;
        moves       <= '0;
      end else begin
        case (state)
          INIT: begin
            if (!idx[4]) begin
              rf_w_enable  <= WR_FULL;
              rf_w_address <= idx[3:0];
              rf_w_data    <= playable(idx[3:0]) ? {init_color, 2'b01} : 14'h0;
              idx          <= idx + 5'd1;
              init_addr    <= idx[3:0] + 4'd1;
            end
          end
          WAIT1: begin
            if (click && playable(click_addr)) begin
              rf_r_address <= click_addr;
              a1           <= click_addr;
            end
          end
          CHK1: begin
            if (covered) begin
              rf_w_enable  <= WR_BITS;
              rf_w_address <= a1;
              rf_w_data    <= {rf_r_data[13:2], 2'b11};
              c1           <= rf_r_data[13:2];
            end
          end
          WAIT2: begin
            if (click && playable(click_addr)) begin
              rf_r_address <= click_addr;
              a2           <= click_addr;
            end
          end
          CHK2: begin
            if (covered) begin
              rf_w_enable  <= WR_BITS;
              rf_w_address <= a2;
              rf_w_data    <= {rf_r_data[13:2], 2'b11};
              c2           <= rf_r_data[13:2];
              cnt          <= CNT_W'(SHOW_CYCLES - 1);
              if (moves != 8'hFF) moves <= moves + 8'd1;
            end
          end
          SHOW: begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else begin
              rf_w_enable  <= WR_BITS;
              rf_w_address <= a1;
              rf_w_data    <= {12'h0, resolve};
            end
          end
          RES1: begin
            rf_w_enable  <= WR_BITS;
            rf_w_address <= a2;
            rf_w_data    <= {12'h0, resolve};
          end
          RES2: begin
            if (matched) pairs_found <= pairs_found + 3'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
